// File: rtl/alu_seq_if.sv
// Decode-to-ALU handshake bundle: request operands in, registered result and flags out.
interface alu_seq_if #(
    parameter int W = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   Opcode;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         out_valid;
    logic [W-1:0] C;
    logic [4:0]   Flags;

    modport master (
        output in_valid, Opcode, A, B,
        input  in_ready, out_valid, C, Flags
    );

    modport slave (
        input  in_valid, Opcode, A, B,
        output in_ready, out_valid, C, Flags
    );
endinterface

// File: rtl/alu_seq.sv
// Registered W-bit ALU with persistent flags (Flags = {Z,C,F,L,N}).
// Define ALU_SEQ_MUL_EN to add the iterative shift-add multiplier (opcode 0E).
module alu_seq #(
    parameter int W   = 16,
    parameter int SHW = $clog2(W)
) (
    input  logic     clk,
    input  logic     reset,
    alu_seq_if.slave bus
);
    localparam logic [W-1:0] W_VAL = W'(W);

    logic [W-1:0] c_q, c_d;
    logic [4:0]   flags_q, flags_d;
    logic         out_valid_q, out_valid_d;
    logic         accept;

    logic [W-1:0]   res;
    logic           n_f, l_f, ov_f, cy_f, z_f, z_set, is_mul;
    logic           cin_en, s_lt, u_lt, sh_big;
    logic [W:0]     add_full, sub_full;
    logic [SHW-1:0] sh_amt;

`ifdef ALU_SEQ_MUL_EN
    localparam int CW = $clog2(W);
    typedef enum logic {IDLE, MUL} state_e;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  acc_q, acc_d, mplr_q, mplr_d, mcand_q, mcand_d;
    logic [W:0]    mstep;

    assign bus.in_ready = (state_q == IDLE) && !reset;
`else
    assign bus.in_ready = !reset;
`endif

    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.C         = c_q;
    assign bus.Flags     = flags_q;
    assign bus.out_valid = out_valid_q;

    // Single-cycle datapath: evaluated on the live inputs, committed only on accept.
    always_comb begin
        res      = '0;
        n_f      = 1'b0;
        l_f      = 1'b0;
        ov_f     = 1'b0;
        cy_f     = flags_q[3];
        z_f      = 1'b0;
        z_set    = 1'b0;
        is_mul   = 1'b0;
        cin_en   = (bus.Opcode == 8'h07) || (bus.Opcode == 8'h70) ||
                   (bus.Opcode == 8'h04) || (bus.Opcode == 8'h40);
        add_full = {1'b0, bus.A} + {1'b0, bus.B} + {{W{1'b0}}, cin_en & flags_q[3]};
        sub_full = {1'b0, bus.A} - {1'b0, bus.B};
        s_lt     = $signed(bus.A) < $signed(bus.B);
        u_lt     = bus.A < bus.B;
        sh_amt   = bus.B[SHW-1:0];
        sh_big   = bus.B >= W_VAL;

        case (bus.Opcode)
            8'h05, 8'h50, 8'h07, 8'h70: begin
                res  = add_full[W-1:0];
                ov_f = (bus.A[W-1] == bus.B[W-1]) && (res[W-1] != bus.A[W-1]);
            end
            8'h06, 8'h60, 8'h04, 8'h40: begin
                res  = add_full[W-1:0];
                cy_f = add_full[W];
            end
            8'h09, 8'h90: begin
                res  = sub_full[W-1:0];
                cy_f = sub_full[W];
                ov_f = (bus.A[W-1] != bus.B[W-1]) && (res[W-1] != bus.A[W-1]);
                n_f  = s_lt;
                l_f  = u_lt;
            end
            8'h0B, 8'hB0, 8'h08, 8'h0C: begin
                n_f   = s_lt;
                l_f   = u_lt;
                z_f   = bus.A == bus.B;
                z_set = 1'b1;
            end
            8'h01, 8'h10: res = bus.A & bus.B;
            8'h02, 8'h20: res = bus.A | bus.B;
            8'h03, 8'h30: res = bus.A ^ bus.B;
            8'h0F:        res = ~bus.A;
            8'h84, 8'h80, 8'h86, 8'h82: res = sh_big ? '0 : bus.A << sh_amt;
            8'h85, 8'h81:               res = sh_big ? '0 : bus.A >> sh_amt;
            8'h87, 8'h83: res = sh_big ? {W{bus.A[W-1]}} : W'($signed(bus.A) >>> sh_amt);
`ifdef ALU_SEQ_MUL_EN
            8'h0E: is_mul = 1'b1;
`endif
            default: begin
                cy_f  = 1'b0;
                z_set = 1'b1;
            end
        endcase

        if (!z_set) z_f = (res == '0);
    end

    always_comb begin
        c_d         = c_q;
        flags_d     = flags_q;
        out_valid_d = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mplr_d  = mplr_q;
        mcand_d = mcand_q;
        mstep   = {1'b0, acc_q} + (mplr_q[0] ? {1'b0, mcand_q} : '0);
`endif

        if (accept && !is_mul) begin
            c_d         = res;
            flags_d     = {z_f, cy_f, ov_f, l_f, n_f};
            out_valid_d = 1'b1;
        end

`ifdef ALU_SEQ_MUL_EN
        if (accept && is_mul) begin
            state_d = MUL;
            cnt_d   = CW'(W - 1);
            acc_d   = '0;
            mplr_d  = bus.B;
            mcand_d = bus.A;
        end

        // {acc, mplr} shifts right each step; low product bits fill mplr from the top.
        if (state_q == MUL) begin
            acc_d  = mstep[W:1];
            mplr_d = {mstep[0], mplr_q[W-1:1]};
            cnt_d  = cnt_q - 1'b1;
            if (cnt_q == '0) begin
                state_d     = IDLE;
                cnt_d       = '0;
                c_d         = mplr_d;
                flags_d     = {(mplr_d == '0), flags_q[3], |acc_d, 2'b00};
                out_valid_d = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            c_q         <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mplr_q  <= '0;
            mcand_q <= '0;
`endif
        end else begin
            c_q         <= c_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
`ifdef ALU_SEQ_MUL_EN
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mplr_q  <= mplr_d;
            mcand_q <= mcand_d;
`endif
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (W=16); MUL scenarios compile in with ALU_SEQ_MUL_EN.
module tb_alu_seq;
    localparam int W = 16;

    typedef struct packed {
        logic [7:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] c;
        logic [4:0]  f;
    } vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    logic [21:0] obs;

    alu_seq_if #(.W(W)) bus ();

    alu_seq #(.W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    assign obs = {bus.out_valid, bus.C, bus.Flags};

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic send(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
        bus.in_valid = 1'b1;
        bus.Opcode   = op;
        bus.A        = a;
        bus.B        = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.in_ready, obs} !== 23'd0) begin
            failures++;
            $display("FAIL reset_state: got rdy/ov/C/F=%h want 0", {bus.in_ready, obs});
        end
        reset = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_reset: got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_add_carry;
        send(8'h06, 16'hFFFF, 16'h0001);
        checks++;
        if (obs !== {1'b1, 16'h0000, 5'b11000}) begin
            failures++;
            $display("FAIL addu_wrap: got %h want %h", obs, {1'b1, 16'h0000, 5'b11000});
        end
        send(8'h04, 16'h0001, 16'h0001);
        checks++;
        if (obs !== {1'b1, 16'h0003, 5'b00000}) begin
            failures++;
            $display("FAIL addcu_chain: got %h want %h", obs, {1'b1, 16'h0003, 5'b00000});
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL out_valid_pulse: got %b want 0", bus.out_valid);
        end
    endtask

    // Issued back to back; carry flag evolves down the table.
    task automatic test_arith;
        vec_t v [14];
        v = '{
            {8'h06, 16'h0001, 16'h0001, 16'h0002, 5'b00000},
            {8'h05, 16'h7FFF, 16'h0001, 16'h8000, 5'b00100},
            {8'h50, 16'h8000, 16'h8000, 16'h0000, 5'b10100},
            {8'h09, 16'h0003, 16'h0005, 16'hFFFE, 5'b01011},
            {8'h0B, 16'hFFFF, 16'h0001, 16'h0000, 5'b01001},
            {8'h08, 16'hFFFF, 16'h0001, 16'h0000, 5'b01001},
            {8'hB0, 16'h1234, 16'h1234, 16'h0000, 5'b11000},
            {8'h0C, 16'h0001, 16'hFFFF, 16'h0000, 5'b01010},
            {8'h07, 16'h0001, 16'h0001, 16'h0003, 5'b01000},
            {8'h90, 16'h8000, 16'h0001, 16'h7FFF, 5'b00101},
            {8'h40, 16'hFFFF, 16'h0000, 16'hFFFF, 5'b00000},
            {8'h09, 16'h0000, 16'h0001, 16'hFFFF, 5'b01011},
            {8'h70, 16'h7FFF, 16'h0000, 16'h8000, 5'b01100},
            {8'h04, 16'h0000, 16'h0000, 16'h0001, 5'b00000}
        };
        foreach (v[i]) begin
            send(v[i].op, v[i].a, v[i].b);
            checks++;
            if (obs !== {1'b1, v[i].c, v[i].f}) begin
                failures++;
                $display("FAIL arith[%0d] op=%h: got %h want %h", i, v[i].op, obs, {1'b1, v[i].c, v[i].f});
            end
        end
    endtask

    task automatic test_logic_shift;
        vec_t v [19];
        v = '{
            {8'h09, 16'h0000, 16'h0001, 16'hFFFF, 5'b01011},
            {8'h01, 16'hF0F0, 16'h0FF0, 16'h00F0, 5'b01000},
            {8'h20, 16'hF000, 16'h000F, 16'hF00F, 5'b01000},
            {8'h03, 16'hAAAA, 16'hAAAA, 16'h0000, 5'b11000},
            {8'h30, 16'hAAAA, 16'h5555, 16'hFFFF, 5'b01000},
            {8'h10, 16'h1234, 16'h0000, 16'h0000, 5'b11000},
            {8'h02, 16'h0000, 16'h0000, 16'h0000, 5'b11000},
            {8'h0F, 16'h0000, 16'h1234, 16'hFFFF, 5'b01000},
            {8'h87, 16'h8000, 16'h0004, 16'hF800, 5'b01000},
            {8'h83, 16'h8000, 16'h0020, 16'hFFFF, 5'b01000},
            {8'h87, 16'h4000, 16'h0010, 16'h0000, 5'b11000},
            {8'h83, 16'h8000, 16'h000F, 16'hFFFF, 5'b01000},
            {8'h84, 16'h0001, 16'h0010, 16'h0000, 5'b11000},
            {8'h80, 16'h0001, 16'h000F, 16'h8000, 5'b01000},
            {8'h85, 16'hF000, 16'h0004, 16'h0F00, 5'b01000},
            {8'h81, 16'h8000, 16'hFFFF, 16'h0000, 5'b11000},
            {8'h86, 16'h0003, 16'h0001, 16'h0006, 5'b01000},
            {8'h82, 16'h0001, 16'h0101, 16'h0000, 5'b11000},
            {8'h85, 16'h8000, 16'h000F, 16'h0001, 5'b01000}
        };
        foreach (v[i]) begin
            send(v[i].op, v[i].a, v[i].b);
            checks++;
            if (obs !== {1'b1, v[i].c, v[i].f}) begin
                failures++;
                $display("FAIL logic_shift[%0d] op=%h: got %h want %h", i, v[i].op, obs, {1'b1, v[i].c, v[i].f});
            end
        end
    endtask

    task automatic test_undef;
        int bad;
        send(8'h09, 16'h0000, 16'h0001);
        send(8'hFF, 16'h1234, 16'h5678);
        checks++;
        if (obs !== {1'b1, 16'h0000, 5'b00000}) begin
            failures++;
            $display("FAIL undef_ff: got %h want %h", obs, {1'b1, 16'h0000, 5'b00000});
        end
`ifndef ALU_SEQ_MUL_EN
        send(8'h09, 16'h0000, 16'h0001);
        send(8'h0E, 16'h0100, 16'h0100);
        checks++;
        if ({bus.in_ready, obs} !== {1'b1, 1'b1, 16'h0000, 5'b00000}) begin
            failures++;
            $display("FAIL undef_mul: got rdy/ov/C/F=%h want %h", {bus.in_ready, obs}, {2'b11, 16'h0000, 5'b00000});
        end
        bad = 0;
        for (int j = 0; j < W + 2; j++) begin
            if (bus.in_ready !== 1'b1) bad++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL undef_mul_ready: got %0d cycles not ready want 0", bad);
        end
`endif
    endtask

    task automatic test_hold;
        send(8'h06, 16'h1234, 16'h1111);
        bus.Opcode = 8'h09;
        bus.A      = 16'hFFFF;
        bus.B      = 16'h0001;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (obs !== {1'b0, 16'h2345, 5'b00000}) begin
            failures++;
            $display("FAIL hold_result: got %h want %h", obs, {1'b0, 16'h2345, 5'b00000});
        end
    endtask

`ifdef ALU_SEQ_MUL_EN
    task automatic test_mul;
        vec_t v [3];
        int   bad;
        v = '{
            {8'h0E, 16'h0100, 16'h0100, 16'h0000, 5'b10100},
            {8'h0E, 16'h0003, 16'h0005, 16'h000F, 5'b00000},
            {8'h0E, 16'hFFFF, 16'hFFFF, 16'h0001, 5'b00100}
        };
        foreach (v[i]) begin
            send(8'h06, 16'h0001, 16'h0001);
            send(v[i].op, v[i].a, v[i].b);
            bad = 0;
            for (int j = 0; j < W; j++) begin
                if ({bus.in_ready, obs} !== {1'b0, 1'b0, 16'h0002, 5'b00000}) bad++;
                @(posedge clk);
                #1;
            end
            checks++;
            if (bad != 0) begin
                failures++;
                $display("FAIL mul_busy[%0d]: got %0d bad busy cycles want 0", i, bad);
            end
            checks++;
            if ({bus.in_ready, obs} !== {1'b1, 1'b1, v[i].c, v[i].f}) begin
                failures++;
                $display("FAIL mul_result[%0d]: got rdy/ov/C/F=%h want %h", i, {bus.in_ready, obs}, {2'b11, v[i].c, v[i].f});
            end
        end
    endtask

    task automatic test_mul_reset;
        int bad;
        send(8'h06, 16'h0001, 16'h0001);
        send(8'h0E, 16'h0100, 16'h0100);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({bus.in_ready, obs} !== 23'd0) begin
            failures++;
            $display("FAIL mul_reset_state: got %h want 0", {bus.in_ready, obs});
        end
        reset = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL mul_reset_ready: got %b want 1", bus.in_ready);
        end
        bad = 0;
        for (int j = 0; j < W + 2; j++) begin
            if (bus.out_valid !== 1'b0) bad++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL mul_reset_no_valid: got %0d pulses want 0", bad);
        end
    endtask
`endif

    task automatic test_reset_mid;
        send(8'h06, 16'hFFFF, 16'h0001);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({bus.in_ready, obs} !== 23'd0) begin
            failures++;
            $display("FAIL reset_mid: got %h want 0", {bus.in_ready, obs});
        end
        reset = 1'b0;
        #1;
    endtask

    initial begin
        clk          = 1'b0;
        reset        = 1'b1;
        checks       = 0;
        failures     = 0;
        bus.in_valid = 1'b0;
        bus.Opcode   = 8'h00;
        bus.A        = '0;
        bus.B        = '0;
        test_reset;
        test_add_carry;
        test_arith;
        test_logic_shift;
        test_undef;
        test_hold;
`ifdef ALU_SEQ_MUL_EN
        test_mul;
        test_mul_reset;
`endif
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
